mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 38 +++
 rtl/ram_be.sv | 30 +++
 rtl/mem_responder.sv | 160 ++++++++++++++++
 tb/tb_mem_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM states, address map and
// RV32I load/store size codes, plus the load-data formatter used in RESP.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic [31:0] RAM_BASE = 32'h0000_0000;
  localparam logic [31:0] LED_ADDR = 32'hFFFF_FF00;
  localparam logic [31:0] CNT_ADDR = 32'hFFFF_FF04;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Pick the addressed byte/half out of a word and sign/zero extend it.
  function automatic logic [31:0] fmt_load(input logic [31:0] w,
                                           input logic [1:0]  off,
                                           input logic [2:0]  f3);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    case (f3)
      F3_B:    fmt_load = {{24{sh[7]}}, sh[7:0]};
      F3_H:    fmt_load = {{16{sh[15]}}, sh[15:0]};
      F3_W:    fmt_load = w;
      F3_BU:   fmt_load = {24'h0, sh[7:0]};
      F3_HU:   fmt_load = {16'h0, sh[15:0]};
      default: fmt_load = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/ram_be.sv
// Synchronous single-port RAM, 32-bit words with per-byte write enables.
// Read data appears the cycle after en; contents are never reset.
module ram_be #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];
  logic [31:0] rdata_q;

  // Byte-masked write and registered read on the same enabled cycle.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: RAM, LED register and free-running
// cycle counter behind a valid/ready request and a one-cycle response strobe.
module mem_responder
  import mem_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  leds
);

  localparam int AW = $clog2(MEM_WORDS);

  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic        err_q, err_d;
  logic        src_reg_q, src_reg_d;
  logic [31:0] regval_q, regval_d;
  logic [7:0]  leds_q, leds_d;
  logic [31:0] cnt_q, cnt_d;

  logic        in_ram, is_led, is_cnt, f3_ok, misalign, acc_err;
  logic [3:0]  st_be;
  logic [31:0] st_data, ram_rdata;
  logic        ram_en;

  // Decode the latched request: target, legality and store byte lanes.
  always_comb begin
    in_ram   = ((addr_q - RAM_BASE) >> (AW + 2)) == 32'h0;
    is_led   = addr_q == LED_ADDR;
    is_cnt   = addr_q == CNT_ADDR;
    case (f3_q)
      F3_B, F3_H, F3_W: f3_ok = 1'b1;
      F3_BU, F3_HU:     f3_ok = !we_q;
      default:          f3_ok = 1'b0;
    endcase
    misalign = ((f3_q == F3_H || f3_q == F3_HU) && addr_q[0]) ||
               (f3_q == F3_W && addr_q[1:0] != 2'b00);
    acc_err  = !f3_ok || misalign || !(in_ram || is_led || is_cnt) ||
               (we_q && is_cnt);
    case (f3_q)
      F3_B: begin
        st_be   = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      F3_H: begin
        st_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = wdata_q;
      end
    endcase
    // A reset edge landing on ACCESS must not commit the store.
    ram_en   = (state_q == ST_ACCESS) && in_ram && !acc_err && !rst;
  end

  ram_be #(.WORDS(MEM_WORDS)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .be    (we_q ? st_be : 4'b0000),
    .addr  (addr_q[AW+1:2]),
    .wdata (st_data),
    .rdata (ram_rdata)
  );

  // FSM sequencing, request capture and register-side effects of ACCESS.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    f3_d      = f3_q;
    err_d     = err_q;
    src_reg_d = src_reg_q;
    regval_d  = regval_q;
    leds_d    = leds_q;
    cnt_d     = cnt_q + 32'd1;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          we_d    = req_we;
          f3_d    = req_funct3;
          wcnt_d  = 4'(WAIT_STATES - 1);
          state_d = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wcnt_q == 4'd0) state_d = ST_ACCESS;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      ST_ACCESS: begin
        err_d     = acc_err;
        src_reg_d = !in_ram;
        regval_d  = is_led ? {24'h0, leds_q} : cnt_q;
        if (we_q && is_led && !acc_err) leds_d = wdata_q[7:0];
        state_d   = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= 4'd0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      err_q     <= 1'b0;
      src_reg_q <= 1'b0;
      regval_q  <= 32'h0;
      leds_q    <= 8'h00;
      cnt_q     <= 32'h0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      err_q     <= err_d;
      src_reg_q <= src_reg_d;
      regval_q  <= regval_d;
      leds_q    <= leds_d;
      cnt_q     <= cnt_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid && err_q;
  // Stores and faults answer with zero data.
  assign rsp_rdata = (rsp_valid && !err_q && !we_q) ?
                     fmt_load(src_reg_q ? regval_q : ram_rdata, addr_q[1:0], f3_q) :
                     32'h0;
  assign leds      = leds_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder with a byte-array reference model plus
// directed literal checks; a second instance runs with zero wait states.
module tb_mem_responder;
  localparam int MW    = 1024;
  localparam int WS    = 1;
  localparam int BYTES = MW * 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  leds;

  logic        z_valid = 1'b0, z_we = 1'b0;
  logic [2:0]  z_funct3 = 3'b0;
  logic [31:0] z_addr = 32'h0, z_wdata = 32'h0;
  logic        z_ready, z_rvalid, z_err;
  logic [31:0] z_rdata;
  logic [7:0]  z_leds;

  mem_responder #(.MEM_WORDS(MW), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_funct3(req_funct3),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .leds(leds));

  mem_responder #(.MEM_WORDS(MW), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(z_valid), .req_ready(z_ready),
    .req_addr(z_addr), .req_we(z_we), .req_funct3(z_funct3),
    .req_wdata(z_wdata), .rsp_valid(z_rvalid), .rsp_rdata(z_rdata),
    .rsp_err(z_err), .leds(z_leds));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mm [BYTES];
  int unsigned cyc = 0;
  bit          m_live = 0, busy = 0, e_valid = 0, e_err = 0, e_ready = 0;
  int          remain = 0;
  logic [31:0] e_rdata = 0;
  logic [7:0]  m_leds = 0;
  bit          p_we;
  logic [2:0]  p_f3;
  logic [31:0] p_addr, p_wd;

  task automatic m_access();
    int sz;
    bit ok, is_ram, is_led, is_cnt;
    logic [31:0] v, mask;
    sz     = (p_f3[1:0] == 2'd0) ? 1 : (p_f3[1:0] == 2'd1) ? 2 : 4;
    ok     = p_we ? (p_f3 <= 3'd2) : (p_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    is_ram = p_addr < BYTES;
    is_led = p_addr == 32'hFFFF_FF00;
    is_cnt = p_addr == 32'hFFFF_FF04;
    if (p_addr % sz != 0) ok = 0;
    if (!(is_ram || is_led || is_cnt) || (p_we && is_cnt)) ok = 0;
    e_err = !ok;
    e_rdata = 0;
    if (ok && p_we) begin
      if (is_ram) for (int i = 0; i < sz; i++) mm[p_addr + i] = p_wd[8*i +: 8];
      else m_leds = p_wd[7:0];
    end else if (ok) begin
      v = 0;
      if (is_ram) for (int i = 0; i < sz; i++) v[8*i +: 8] = mm[p_addr + i];
      else v = is_led ? {24'h0, m_leds} : cyc;
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
      v = v & mask;
      if (!p_f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
      e_rdata = v;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      busy = 0; e_valid = 0; e_err = 0; e_rdata = 0; e_ready = 1;
      m_leds = 0; cyc = 0; m_live = 1;
    end else begin
      if (e_valid) begin
        e_valid = 0; e_err = 0; e_rdata = 0; busy = 0;
      end else if (busy) begin
        remain--;
        if (remain == 0) begin m_access(); e_valid = 1; end
      end else if (req_valid) begin
        busy = 1; remain = WS + 1;
        p_we = req_we; p_f3 = req_funct3; p_addr = req_addr; p_wd = req_wdata;
      end
      e_ready = !busy;
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
      chk("rsp_err", 32'(rsp_err), 32'(e_err));
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("leds", 32'(leds), 32'(m_leds));
    end
  end

  // ---------------- driver ----------------
  bit sel = 0;
  logic a_ready, a_valid, a_err;
  logic [31:0] a_rdata;
  assign a_ready = sel ? z_ready  : req_ready;
  assign a_valid = sel ? z_rvalid : rsp_valid;
  assign a_err   = sel ? z_err    : rsp_err;
  assign a_rdata = sel ? z_rdata  : rsp_rdata;

  task automatic put(input bit v, input bit we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd);
    if (!sel) begin req_valid = v; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; end
    else begin z_valid = v; z_we = we; z_funct3 = f3; z_addr = a; z_wdata = wd; end
  endtask

  task automatic xact(input bit we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output bit er,
                      output int lat);
    int n;
    rd = 0; er = 0; lat = -1;
    @(negedge clk);
    put(1'b1, we, f3, a, wd);
    n = 0;
    while (!a_ready && n < 50) begin @(negedge clk); n++; end
    if (!a_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: req_ready never seen for addr %h", a);
      put(1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    put(1'b0, $urandom_range(0, 1), 3'($urandom), $urandom, $urandom);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (a_valid) begin lat = k; rd = a_rdata; er = a_err; break; end
    end
    if (lat < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_timeout: no rsp_valid for addr %h", a);
    end
  endtask

  // Directed table: we, funct3, addr, wdata, expected rdata, expected err.
  typedef struct { bit we; logic [2:0] f3; logic [31:0] a; logic [31:0] wd;
                   logic [31:0] xr; bit xe; string nm; } vec_t;
  vec_t dir [] = '{
    '{1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, "sw_10"},
    '{0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, "lw_10"},
    '{1, 3'b000, 32'h13, 32'h00000080, 32'h0, 0, "sb_13"},
    '{0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 0, "lb_13"},
    '{0, 3'b100, 32'h13, 32'h0, 32'h00000080, 0, "lbu_13"},
    '{0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 0, "lw_10_b"},
    '{0, 3'b001, 32'h12, 32'h0, 32'hFFFF80AD, 0, "lh_12"},
    '{0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 0, "lhu_10"},
    '{0, 3'b010, 32'h12, 32'h0, 32'h0, 1, "lw_mis"},
    '{0, 3'b001, 32'h11, 32'h0, 32'h0, 1, "lh_mis"},
    '{0, 3'b010, 32'h80000000, 32'h0, 32'h0, 1, "lw_unmap"},
    '{0, 3'b011, 32'h10, 32'h0, 32'h0, 1, "f3_011"},
    '{1, 3'b010, 32'h12, 32'h11111111, 32'h0, 1, "sw_mis"},
    '{1, 3'b011, 32'h10, 32'h22222222, 32'h0, 1, "sf3_011"},
    '{0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 0, "lw_10_unch"},
    '{0, 3'b010, BYTES, 32'h0, 32'h0, 1, "lw_past_end"},
    '{1, 3'b010, 32'hFFFFFF00, 32'h000000A5, 32'h0, 0, "sw_led"},
    '{1, 3'b010, 32'hFFFFFF04, 32'h5, 32'h0, 1, "sw_cnt"}
  };

  initial begin
    logic [31:0] rd, c1, c2;
    bit er, seen;
    int lat;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_leds", 32'(leds), 32'd0);
    rst = 0;

    for (int i = 0; i < 16; i++) xact(1, 3'b010, 32'(4 * i), $urandom, rd, er, lat);
    for (int i = 1; i <= 4; i++) xact(1, 3'b010, 32'(BYTES - 4 * i), $urandom, rd, er, lat);
    xact(1, 3'b010, 32'h20, 32'h0BADF00D, rd, er, lat);

    foreach (dir[i]) begin
      xact(dir[i].we, dir[i].f3, dir[i].a, dir[i].wd, rd, er, lat);
      chk({dir[i].nm, "_rdata"}, rd, dir[i].xr);
      chk({dir[i].nm, "_err"}, 32'(er), 32'(dir[i].xe));
      chk({dir[i].nm, "_lat"}, 32'(lat), 32'(WS + 1));
    end
    chk("leds_a5", 32'(leds), 32'hA5);

    xact(0, 3'b010, 32'hFFFFFF04, 0, c1, er, lat);
    repeat (5) @(negedge clk);
    xact(0, 3'b010, 32'hFFFFFF04, 0, c2, er, lat);
    chk("cnt_delta", c2 - c1, 32'(5 + WS + 2));

    // Reset during WAIT of a store: no response, no commit, LEDs cleared.
    @(negedge clk);
    for (int n = 0; n < 10 && !req_ready; n++) @(negedge clk);
    put(1, 1, 3'b010, 32'h20, 32'h12345678);
    @(posedge clk);
    @(negedge clk);
    put(0, 0, 3'b0, 32'h0, 32'h0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (rsp_valid) seen = 1; end
    chk("rst_no_rsp", 32'(seen), 32'd0);
    chk("rst_leds_0", 32'(leds), 32'd0);
    xact(0, 3'b010, 32'h20, 0, rd, er, lat);
    chk("rst_lw_20", rd, 32'h0BADF00D);

    for (int t = 0; t < 400; t++) begin
      int k;
      logic [31:0] a;
      logic [2:0] f3;
      bit we;
      k = $urandom_range(0, 9);
      if (k <= 5)      a = $urandom_range(0, 63);
      else if (k == 6) a = 32'(BYTES - 16) + $urandom_range(0, 15);
      else if (k == 7) a = 32'(BYTES) + $urandom_range(0, 7);
      else if (k == 8) a = 32'hFFFFFF00 + $urandom_range(0, 7);
      else             a = $urandom | 32'h4000_0000;
      we = $urandom_range(0, 1);
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      if (!we && $urandom_range(0, 2) == 0) f3 = 3'($urandom_range(4, 5));
      xact(we, f3, a, $urandom, rd, er, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Zero wait states: response one edge after acceptance.
    sel = 1;
    xact(1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("ws0_sw_lat", 32'(lat), 32'd1);
    chk("ws0_sw_err", 32'(er), 32'd0);
    xact(0, 3'b010, 32'h10, 0, rd, er, lat);
    chk("ws0_lw_lat", 32'(lat), 32'd1);
    chk("ws0_lw_rdata", rd, 32'hDEADBEEF);
    chk("ws0_lw_err", 32'(er), 32'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
